inst_fetch: RTL and testbench

Instruction fetch stage for the RV32I datapath. Holds the PC, issues word reads to instruction memory over a valid/ready request channel with at most one request outstanding, and buffers returned words with their PCs in a small FIFO. Supplies `inst` to the decode/execute fragment through a valid/ready handshake. A redirect input (branch/jump) flushes buffered and in-flight instructions and restarts fetch at a new PC.

---
 rtl/inst_fetch_pkg.sv | 17 +
 rtl/inst_fetch_fifo.sv | 61 ++++++
 rtl/inst_fetch.sv | 111 +++++++++++
 tb/tb_inst_fetch.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the RV32I instruction fetch stage: the fetch FSM encoding,
// the NOP word shown when the buffer is empty, and PC word alignment.
package inst_fetch_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WAIT  = 2'b01,
        DRAIN = 2'b10
    } fetch_state_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_fifo.sv
// Small circular buffer of {pc, word} entries between the fetch FSM and decode.
// Flush wins over push and pop. A pop is ignored when the buffer is empty.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    input  logic                       i_flush,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic [WIDTH-1:0]           o_head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_pop;

    assign w_do_pop = i_pop && (r_count != '0);
    assign o_count  = r_count;
    assign o_head   = r_mem[r_rd_ptr];

    // Pointers and count are control; only they see reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({i_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// RV32I fetch stage: PC register, single-outstanding imem request FSM and an
// instruction buffer; redirect flushes buffered and in-flight instructions.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    fetch_state_t  r_state;
    fetch_state_t  w_state_nxt;
    logic          r_run;
    logic [31:0]   r_pc;
    logic [31:0]   r_inflight_pc;
    logic          w_req_hs;
    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_count;
    logic [63:0]   w_head;

    assign imem_req_valid = r_run && (r_state == IDLE) && (w_count < FULL_CNT);
    assign imem_req_addr  = r_pc;
    assign w_req_hs       = imem_req_valid && imem_req_ready;

    // A response landing in the same cycle as a redirect belongs to the old stream.
    assign w_push = (r_state == WAIT) && imem_resp_valid && !redirect_valid;
    assign w_pop  = inst_valid && inst_ready && !redirect_valid;

    assign inst_valid = (w_count != '0);
    assign inst       = inst_valid ? w_head[31:0]  : NOP_INST;
    assign inst_pc    = inst_valid ? w_head[63:32] : 32'h0000_0000;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_req_hs) begin
                    w_state_nxt = redirect_valid ? DRAIN : WAIT;
                end
            end
            WAIT: begin
                if (imem_resp_valid) begin
                    w_state_nxt = IDLE;
                end else if (redirect_valid) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // The drained response ends DRAIN even if another redirect arrives with it.
                if (imem_resp_valid) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_run   <= 1'b0;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            r_run   <= 1'b1;
            if (redirect_valid) begin
                r_pc <= word_align(redirect_pc);
            end else if (w_req_hs) begin
                r_pc <= r_pc + 32'd4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_req_hs) begin
            r_inflight_pc <= r_pc;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  ({r_inflight_pc, imem_resp_data}),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .o_count (w_count),
        .o_head  (w_head)
    );

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a behavioural instruction memory whose
// response latency and request-ready are set per step; word at address A is ~A.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        inst_valid;
    logic        inst_ready = 1'b1;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    int checks = 0;
    int errors = 0;
    int lat = 1;

    logic        m_pend;
    int          m_cnt;
    logic [31:0] m_addr;

    inst_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .inst_pc         (inst_pc)
    );

    always #5 clk = ~clk;

    // Memory: response is high k cycles after the accepting cycle; forgets everything on reset.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_pend          <= 1'b0;
            m_cnt           <= 0;
            m_addr          <= 32'h0;
            imem_resp_valid <= 1'b0;
            imem_resp_data  <= 32'h0;
        end else begin
            imem_resp_valid <= 1'b0;
            if (m_pend) begin
                if (m_cnt == 1) begin
                    imem_resp_valid <= 1'b1;
                    imem_resp_data  <= ~m_addr;
                    m_pend          <= 1'b0;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
            if (imem_req_valid && imem_req_ready) begin
                if (lat == 1) begin
                    imem_resp_valid <= 1'b1;
                    imem_resp_data  <= ~imem_req_addr;
                end else begin
                    m_pend <= 1'b1;
                    m_cnt  <= lat - 1;
                    m_addr <= imem_req_addr;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Leaves the bench at cycle 0 after release; the next step() lands in cycle 1.
    task automatic do_reset(input int k, input logic mready, input logic iready);
        rst            = 1'b0;
        redirect_valid = 1'b0;
        lat            = k;
        imem_req_ready = mready;
        inst_ready     = iready;
        step();
        step();
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
        chk("rst_req_addr", imem_req_addr, 32'h0);
        chk("rst_inst_valid", {31'b0, inst_valid}, 32'h0);
        chk("rst_inst", inst, 32'h0000_0013);
        chk("rst_inst_pc", inst_pc, 32'h0);
        rst = 1'b1;
    endtask

    initial begin
        // Streaming, k=1, always ready
        do_reset(1, 1'b1, 1'b1);
        step();
        chk("s_c1_req_valid", {31'b0, imem_req_valid}, 32'h1);
        chk("s_c1_addr", imem_req_addr, 32'h0);
        step();
        chk("s_c2_req_valid", {31'b0, imem_req_valid}, 32'h0);
        chk("s_c2_inst_valid", {31'b0, inst_valid}, 32'h0);
        step();
        chk("s_c3_inst_valid", {31'b0, inst_valid}, 32'h1);
        chk("s_c3_inst_pc", inst_pc, 32'h0);
        chk("s_c3_inst", inst, 32'hFFFF_FFFF);
        chk("s_c3_addr", imem_req_addr, 32'h4);
        step();
        chk("s_c4_inst_valid", {31'b0, inst_valid}, 32'h0);
        step();
        chk("s_c5_inst_pc", inst_pc, 32'h4);
        chk("s_c5_inst", inst, 32'hFFFF_FFFB);
        chk("s_c5_addr", imem_req_addr, 32'h8);
        step();
        step();
        chk("s_c7_inst_pc", inst_pc, 32'h8);
        chk("s_c7_inst", inst, 32'hFFFF_FFF7);
        chk("s_c7_addr", imem_req_addr, 32'hC);

        // Backpressure from decode fills the buffer
        do_reset(1, 1'b1, 1'b0);
        step();
        step();
        step();
        chk("bp_c3_addr", imem_req_addr, 32'h4);
        chk("bp_c3_req_valid", {31'b0, imem_req_valid}, 32'h1);
        step();
        step();
        chk("bp_c5_req_valid", {31'b0, imem_req_valid}, 32'h0);
        chk("bp_c5_inst_pc", inst_pc, 32'h0);
        step();
        chk("bp_c6_req_valid", {31'b0, imem_req_valid}, 32'h0);
        inst_ready = 1'b1;
        step();
        chk("bp_c7_req_valid", {31'b0, imem_req_valid}, 32'h1);
        chk("bp_c7_addr", imem_req_addr, 32'h8);
        chk("bp_c7_inst_pc", inst_pc, 32'h4);
        chk("bp_c7_inst", inst, 32'hFFFF_FFFB);

        // Memory not ready: request held stable
        do_reset(1, 1'b0, 1'b1);
        for (int c = 1; c <= 4; c++) begin
            step();
            chk("hold_req_valid", {31'b0, imem_req_valid}, 32'h1);
            chk("hold_addr", imem_req_addr, 32'h0);
        end
        imem_req_ready = 1'b1;
        step();
        chk("hold_c5_req_valid", {31'b0, imem_req_valid}, 32'h0);
        step();
        chk("hold_c6_inst_valid", {31'b0, inst_valid}, 32'h1);
        chk("hold_c6_inst_pc", inst_pc, 32'h0);

        // Redirect while WAIT with k=3 and one entry buffered
        do_reset(3, 1'b1, 1'b0);
        repeat (5) step();
        chk("rw_c5_inst_valid", {31'b0, inst_valid}, 32'h1);
        chk("rw_c5_addr", imem_req_addr, 32'h4);
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        step();
        redirect_valid = 1'b0;
        chk("rw_c7_inst_valid", {31'b0, inst_valid}, 32'h0);
        chk("rw_c7_req_valid", {31'b0, imem_req_valid}, 32'h0);
        step();
        chk("rw_c8_req_valid", {31'b0, imem_req_valid}, 32'h0);
        step();
        chk("rw_c9_req_valid", {31'b0, imem_req_valid}, 32'h1);
        chk("rw_c9_addr", imem_req_addr, 32'h0000_0100);
        chk("rw_c9_inst_valid", {31'b0, inst_valid}, 32'h0);
        inst_ready = 1'b1;
        repeat (4) step();
        chk("rw_c13_inst_valid", {31'b0, inst_valid}, 32'h1);
        chk("rw_c13_inst_pc", inst_pc, 32'h0000_0100);
        chk("rw_c13_inst", inst, 32'hFFFF_FEFF);

        // Redirect in the same cycle as the response
        do_reset(1, 1'b1, 1'b1);
        step();
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        step();
        redirect_valid = 1'b0;
        chk("rr_c3_req_valid", {31'b0, imem_req_valid}, 32'h1);
        chk("rr_c3_addr", imem_req_addr, 32'h0000_0200);
        chk("rr_c3_inst_valid", {31'b0, inst_valid}, 32'h0);
        step();
        step();
        chk("rr_c5_inst_pc", inst_pc, 32'h0000_0200);
        chk("rr_c5_inst", inst, 32'hFFFF_FDFF);

        // Redirect in the same cycle as the request handshake
        do_reset(2, 1'b1, 1'b1);
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0300;
        step();
        redirect_valid = 1'b0;
        chk("rh_c2_req_valid", {31'b0, imem_req_valid}, 32'h0);
        step();
        chk("rh_c3_req_valid", {31'b0, imem_req_valid}, 32'h0);
        step();
        chk("rh_c4_inst_valid", {31'b0, inst_valid}, 32'h0);
        chk("rh_c4_addr", imem_req_addr, 32'h0000_0300);
        chk("rh_c4_req_valid", {31'b0, imem_req_valid}, 32'h1);
        repeat (3) step();
        chk("rh_c7_inst_pc", inst_pc, 32'h0000_0300);
        chk("rh_c7_inst", inst, 32'hFFFF_FCFF);

        // PC wrap at the top of the address space, then reset mid-WAIT
        do_reset(1, 1'b0, 1'b0);
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        step();
        redirect_valid = 1'b0;
        chk("wr_c2_addr", imem_req_addr, 32'hFFFF_FFFC);
        imem_req_ready = 1'b1;
        step();
        step();
        chk("wr_c4_inst_pc", inst_pc, 32'hFFFF_FFFC);
        chk("wr_c4_inst", inst, 32'h0000_0003);
        chk("wr_c4_addr", imem_req_addr, 32'h0000_0000);
        lat = 3;
        step();
        chk("wr_c5_req_valid", {31'b0, imem_req_valid}, 32'h0);
        chk("wr_c5_addr", imem_req_addr, 32'h0000_0004);
        rst = 1'b0;
        #1;
        chk("ar_inst_valid", {31'b0, inst_valid}, 32'h0);
        chk("ar_addr", imem_req_addr, 32'h0000_0000);
        chk("ar_inst", inst, 32'h0000_0013);
        step();
        rst = 1'b1;
        inst_ready = 1'b1;
        step();
        chk("ar_c1_req_valid", {31'b0, imem_req_valid}, 32'h1);
        chk("ar_c1_addr", imem_req_addr, 32'h0);
        repeat (4) step();
        chk("ar_c5_inst_valid", {31'b0, inst_valid}, 32'h1);
        chk("ar_c5_inst_pc", inst_pc, 32'h0);
        chk("ar_c5_inst", inst, 32'hFFFF_FFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
